// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the BCD stopwatch: controller states and BCD digit limits.
// The limits are plain localparams so the countdown timer can reuse them.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    MAXED = 2'd3
  } sw_state_e;

  localparam logic [3:0] MAX_ONES = 4'd9;
  localparam logic [3:0] MAX_TENS = 4'd5;

  // True when the packed {Mt, Mo, St, So} count shows 59:59.
  function automatic logic is_max_count(input logic [15:0] count);
    return count == {MAX_TENS, MAX_ONES, MAX_TENS, MAX_ONES};
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT and rolls over, raising Carry on the rollover increment.
module bcd_digit_counter
  import stopwatch_bcd_pkg::*;
#(
  parameter logic [3:0] LIMIT = MAX_ONES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Inc,
  output logic [3:0] Digit,
  output logic       Carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  assign Carry = Inc && (digit_q == LIMIT);
  assign Digit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (Clear) begin
      digit_d = 4'd0;
    end else if (Inc) begin
      digit_d = (digit_q == LIMIT) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Count-up MM:SS stopwatch in BCD with run/pause, synchronous clear and lap freeze.
// Contains its own one-second divider; Out drives four hex display digits.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int WRAP          = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        StartStop,
  input  logic        Clear,
  input  logic        Lap,
  output logic [15:0] Out,
  output logic        Running,
  output logic        Frozen,
  output logic        MaxReached
);

  localparam int DIV_W = $clog2(TICKS_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  sw_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ss_prev_q, lap_prev_q;
  logic             frozen_q, frozen_d;
  logic [15:0]      lap_q, lap_d;
  logic [15:0]      out_q, out_d;

  logic        ss_rise, lap_rise, tick, hold_max, inc_so;
  logic [3:0]  so, st, mo, mt;
  logic        so_carry, st_carry, mo_carry, mt_carry_unused;
  logic [15:0] count;

  // Edges seen while Clear is high are dropped, but the history still tracks the inputs.
  assign ss_rise  = StartStop && !ss_prev_q && !Clear;
  assign lap_rise = Lap && !lap_prev_q && !Clear;
  assign tick     = (state_q == RUN) && (div_q == DIV_LAST);
  assign count    = {mt, mo, st, so};
  assign hold_max = is_max_count(count) && (WRAP == 0);
  assign inc_so   = tick && !hold_max && !Clear;

  bcd_digit_counter #(.LIMIT(MAX_ONES)) u_so (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Inc(inc_so),   .Digit(so), .Carry(so_carry)
  );
  bcd_digit_counter #(.LIMIT(MAX_TENS)) u_st (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Inc(so_carry), .Digit(st), .Carry(st_carry)
  );
  bcd_digit_counter #(.LIMIT(MAX_ONES)) u_mo (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Inc(st_carry), .Digit(mo), .Carry(mo_carry)
  );
  bcd_digit_counter #(.LIMIT(MAX_TENS)) u_mt (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Inc(mo_carry), .Digit(mt), .Carry(mt_carry_unused)
  );

  // A saturating tick wins over a simultaneous StartStop rise.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    if (Clear) begin
      state_d = IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          div_d = '0;
          if (ss_rise) state_d = RUN;
        end
        RUN: begin
          div_d = tick ? '0 : div_q + DIV_ONE;
          if (tick && hold_max) state_d = MAXED;
          else if (ss_rise)     state_d = PAUSE;
        end
        PAUSE: begin
          if (ss_rise) state_d = RUN;
        end
        MAXED: begin
          div_d = '0;
        end
        default: begin
          state_d = IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    frozen_d = frozen_q;
    lap_d    = lap_q;
    if (Clear) begin
      frozen_d = 1'b0;
    end else if (lap_rise) begin
      if (frozen_q) begin
        frozen_d = 1'b0;
      end else begin
        frozen_d = 1'b1;
        lap_d    = count;
      end
    end
  end

  always_comb begin
    out_d = frozen_q ? lap_q : count;
    if (Clear) out_d = 16'h0000;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
      frozen_q   <= 1'b0;
      lap_q      <= 16'h0000;
      out_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ss_prev_q  <= StartStop;
      lap_prev_q <= Lap;
      frozen_q   <= frozen_d;
      lap_q      <= lap_d;
      out_q      <= out_d;
    end
  end

  assign Out        = out_q;
  assign Running    = (state_q == RUN);
  assign MaxReached = (state_q == MAXED);
  assign Frozen     = frozen_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: a saturating instance (4 ticks/s) and a wrapping
// instance (2 ticks/s) are compared every cycle against an elapsed-seconds reference model.
module tb_stopwatch_bcd;

  localparam int TPS_A = 4;
  localparam int TPS_B = 2;

  int tps  [2] = '{TPS_A, TPS_B};
  bit wrap [2] = '{1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss  [2];
  logic clr [2];
  logic lap [2];
  logic [15:0] out_w [2];
  logic run_w [2];
  logic frz_w [2];
  logic max_w [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: whole elapsed seconds, cycles into the current second, and flags.
  int m_secs [2];
  int m_sub  [2];
  int m_lap  [2];
  int m_out  [2];
  bit m_run [2];
  bit m_max [2];
  bit m_frozen [2];
  bit m_ss_prev [2];
  bit m_lap_prev [2];

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICKS_PER_SEC(TPS_A), .WRAP(0)) dut_a (
    .Clock(clk), .Reset(rst), .StartStop(ss[0]), .Clear(clr[0]), .Lap(lap[0]),
    .Out(out_w[0]), .Running(run_w[0]), .Frozen(frz_w[0]), .MaxReached(max_w[0])
  );

  stopwatch_bcd #(.TICKS_PER_SEC(TPS_B), .WRAP(1)) dut_b (
    .Clock(clk), .Reset(rst), .StartStop(ss[1]), .Clear(clr[1]), .Lap(lap[1]),
    .Out(out_w[1]), .Running(run_w[1]), .Frozen(frz_w[1]), .MaxReached(max_w[1])
  );

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_secs[i] = 0; m_sub[i] = 0; m_lap[i] = 0; m_out[i] = 0;
      m_run[i] = 1'b0; m_max[i] = 1'b0; m_frozen[i] = 1'b0;
      m_ss_prev[i] = 1'b0; m_lap_prev[i] = 1'b0;
    end
  endtask

  task automatic modelEdge(input int i);
    bit ss_r;
    bit lap_r;
    ss_r  = ss[i] && !m_ss_prev[i];
    lap_r = lap[i] && !m_lap_prev[i];
    m_ss_prev[i]  = ss[i];
    m_lap_prev[i] = lap[i];
    if (clr[i]) begin
      m_out[i] = 0; m_secs[i] = 0; m_sub[i] = 0;
      m_run[i] = 1'b0; m_max[i] = 1'b0; m_frozen[i] = 1'b0;
    end else begin
      m_out[i] = m_frozen[i] ? m_lap[i] : m_secs[i];
      if (lap_r) begin
        if (m_frozen[i]) m_frozen[i] = 1'b0;
        else begin
          m_lap[i]    = m_secs[i];
          m_frozen[i] = 1'b1;
        end
      end
      if (m_max[i]) begin
        m_max[i] = 1'b1;
      end else if (m_run[i]) begin
        if (m_sub[i] == tps[i] - 1) begin
          m_sub[i] = 0;
          if (m_secs[i] == 3599) begin
            if (wrap[i]) m_secs[i] = 0;
            else begin
              m_max[i] = 1'b1;
              m_run[i] = 1'b0;
            end
          end else begin
            m_secs[i] = m_secs[i] + 1;
          end
        end else begin
          m_sub[i] = m_sub[i] + 1;
        end
        if (ss_r && !m_max[i]) m_run[i] = 1'b0;
      end else if (ss_r) begin
        m_run[i] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out%0d", i),     out_w[i],           to_bcd(m_out[i]));
      check($sformatf("running%0d", i), {15'd0, run_w[i]},  {15'd0, m_run[i]});
      check($sformatf("frozen%0d", i),  {15'd0, frz_w[i]},  {15'd0, m_frozen[i]});
      check($sformatf("maxed%0d", i),   {15'd0, max_w[i]},  {15'd0, m_max[i]});
    end
  endtask

  // One clock: the model sees the same inputs as the DUTs, outputs are checked 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkOutput();
  endtask

  task automatic waitModel(input int i, input logic [15:0] target, input int limit);
    int n = 0;
    while (to_bcd(m_out[i]) != target && n < limit) begin
      applyStimulus();
      n++;
    end
    check($sformatf("reach%0d_%h", i, target), out_w[i], target);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ss[i] = 1'b0; clr[i] = 1'b0; lap[i] = 1'b0;
    end
    modelReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // Three seconds of running at 4 ticks per second.
    ss[0] = 1'b1; applyStimulus();
    ss[0] = 1'b0; applyStimulus();
    repeat (12) applyStimulus();
    check("run3_out", out_w[0], 16'h0003);
    check("run3_running", {15'd0, run_w[0]}, 16'h0001);

    // Pause two cycles into a second, then resume and finish that second.
    clr[0] = 1'b1; applyStimulus();
    clr[0] = 1'b0; applyStimulus();
    ss[0] = 1'b1; applyStimulus();
    ss[0] = 1'b0;
    repeat (6) applyStimulus();
    check("pause_pre_out", out_w[0], 16'h0001);
    ss[0] = 1'b1; applyStimulus();
    ss[0] = 1'b0;
    repeat (20) applyStimulus();
    check("paused_out", out_w[0], 16'h0001);
    check("paused_running", {15'd0, run_w[0]}, 16'h0000);
    ss[0] = 1'b1; applyStimulus();
    ss[0] = 1'b0; applyStimulus();
    check("resume1_out", out_w[0], 16'h0001);
    applyStimulus();
    check("resume2_out", out_w[0], 16'h0002);

    // Lap freeze at 00:05 held over three ticks, then released.
    waitModel(0, 16'h0005, 100);
    lap[0] = 1'b1; applyStimulus();
    lap[0] = 1'b0;
    repeat (10) applyStimulus();
    check("lap_hold_out", out_w[0], 16'h0005);
    check("lap_hold_frozen", {15'd0, frz_w[0]}, 16'h0001);
    lap[0] = 1'b1; applyStimulus();
    lap[0] = 1'b0; applyStimulus();
    check("lap_release_out", out_w[0], 16'h0008);
    check("lap_release_frozen", {15'd0, frz_w[0]}, 16'h0000);

    // Clear coinciding with a tick, a StartStop rise and a Lap rise.
    begin
      int n = 0;
      while (m_sub[0] != tps[0] - 1 && n < 10) begin
        applyStimulus();
        n++;
      end
    end
    check("pre_clear_running", {15'd0, run_w[0]}, 16'h0001);
    clr[0] = 1'b1; ss[0] = 1'b1; lap[0] = 1'b1; applyStimulus();
    check("clear_out", out_w[0], 16'h0000);
    check("clear_running", {15'd0, run_w[0]}, 16'h0000);
    check("clear_frozen", {15'd0, frz_w[0]}, 16'h0000);
    clr[0] = 1'b0; ss[0] = 1'b0; lap[0] = 1'b0; applyStimulus();
    check("post_clear_out", out_w[0], 16'h0000);
    check("post_clear_running", {15'd0, run_w[0]}, 16'h0000);

    // Random control activity on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        ss[i]  = ($urandom_range(0, 3) == 0);
        lap[i] = ($urandom_range(0, 5) == 0);
        clr[i] = ($urandom_range(0, 40) == 0);
      end
      applyStimulus();
    end
    for (int i = 0; i < 2; i++) begin
      ss[i] = 1'b0; clr[i] = 1'b0; lap[i] = 1'b0;
    end
    applyStimulus();

    // Asynchronous reset pulse between clock edges.
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_out%0d", i), out_w[i], 16'h0000);
      check($sformatf("async_running%0d", i), {15'd0, run_w[i]}, 16'h0000);
      check($sformatf("async_frozen%0d", i), {15'd0, frz_w[i]}, 16'h0000);
      check($sformatf("async_maxed%0d", i), {15'd0, max_w[i]}, 16'h0000);
    end
    modelReset();
    #1 rst = 1'b0;

    // Long run: minute and ten-minute carries, then wrap and saturation at 59:59.
    ss[0] = 1'b1; ss[1] = 1'b1; applyStimulus();
    ss[0] = 1'b0; ss[1] = 1'b0; applyStimulus();
    waitModel(1, 16'h0059, 400);
    repeat (2) applyStimulus();
    check("minute_carry", out_w[1], 16'h0100);
    waitModel(1, 16'h0959, 2000);
    repeat (2) applyStimulus();
    check("ten_minute_carry", out_w[1], 16'h1000);
    waitModel(1, 16'h5959, 8000);
    repeat (2) applyStimulus();
    check("wrap_out", out_w[1], 16'h0000);
    check("wrap_running", {15'd0, run_w[1]}, 16'h0001);
    waitModel(0, 16'h5959, 16000);
    repeat (4) applyStimulus();
    check("sat_out", out_w[0], 16'h5959);
    check("sat_maxed", {15'd0, max_w[0]}, 16'h0001);
    check("sat_running", {15'd0, run_w[0]}, 16'h0000);
    ss[0] = 1'b1; applyStimulus();
    ss[0] = 1'b0; applyStimulus();
    check("sat_ss_out", out_w[0], 16'h5959);
    check("sat_ss_maxed", {15'd0, max_w[0]}, 16'h0001);
    check("sat_ss_running", {15'd0, run_w[0]}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
